alu_result_select: RTL and testbench

//  Parametrised, handshaked N:1 result selector for the ALU output path. Takes one op code
//  per request and waits for the selected functional unit's result to become valid; multi-

---
 rtl/alu_sel_pkg.sv | 22 ++
 rtl/result_fifo2.sv | 48 ++++
 rtl/alu_result_select.sv | 154 +++++++++++++++
 tb/tb_alu_result_select.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sel_pkg.sv
// Shared definitions for the ALU result selector: FSM state encoding,
// ALU op-code constants and default datapath sizes.
package alu_sel_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_NUM_IN = 8;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_NOR = 3'd6;
    localparam logic [2:0] OP_MOD = 3'd7;

endpackage

// File: rtl/result_fifo2.sv
// Two-entry in-order result buffer; the head output keeps showing the most
// recently popped entry while the buffer is empty.
module result_fifo2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [1:0]    count,
    output logic [DW-1:0] head
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic          do_pop;

    assign do_pop = pop & (count != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // When empty, the slot behind the read pointer holds the last entry that left.
    assign head = (count == 2'd0) ? mem[~rd_ptr] : mem[rd_ptr];

endmodule

// File: rtl/alu_result_select.sv
// Handshaked N:1 ALU result selector: waits for the chosen unit's result,
// with timeout and illegal-op reporting, and queues results in a 2-entry buffer.
module alu_result_select
    import alu_sel_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_IN  = DEF_NUM_IN,
    parameter int SEL_W   = $clog2(NUM_IN),
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [SEL_W-1:0]        req_op,
    input  logic                    req_valid,
    output logic                    req_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_op,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
);

    localparam int TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int NSEL = 1 << SEL_W;
    localparam int DW   = WIDTH + SEL_W + 1;
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state;
    state_t            next_state;
    logic [SEL_W-1:0]  op_q;
    logic [SEL_W-1:0]  sel;
    logic [TW-1:0]     timer;
    logic [NSEL-1:0]   valid_pad;
    logic [WIDTH-1:0]  sel_data;
    logic [WIDTH-1:0]  push_dat;
    logic              op_illegal;
    logic              accept;
    logic              timed_out;
    logic              push;
    logic              push_err;
    logic              pop;
    logic              start_wait;
    logic              timer_inc;
    logic [1:0]        count;
    logic [DW-1:0]     push_word;
    logic [DW-1:0]     head;

    assign sel = (state == IDLE) ? req_op : op_q;

    // Zero-extend the valid vector so any select code indexes a defined bit.
    always_comb begin
        valid_pad               = '0;
        valid_pad[NUM_IN-1:0]   = in_valid;
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    generate
        if (NUM_IN < NSEL) begin : g_illegal
            assign op_illegal = ({1'b0, req_op} >= (SEL_W + 1)'(NUM_IN));
        end else begin : g_no_illegal
            assign op_illegal = 1'b0;
        end
    endgenerate

    assign req_ready = (state == IDLE) && (count != 2'd2);
    assign accept    = req_valid & req_ready;
    assign timed_out = (TIMEOUT != 0) && (timer == T_LAST);
    assign busy      = (state == WAIT);

    // Next state and push decisions; a valid result outranks a coincident timeout.
    always_comb begin
        next_state = state;
        push       = 1'b0;
        push_err   = 1'b0;
        start_wait = 1'b0;
        timer_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (op_illegal) begin
                        push     = 1'b1;
                        push_err = 1'b1;
                    end else if (valid_pad[sel]) begin
                        push = 1'b1;
                    end else begin
                        start_wait = 1'b1;
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (valid_pad[sel]) begin
                    push       = 1'b1;
                    next_state = IDLE;
                end else if (timed_out) begin
                    push       = 1'b1;
                    push_err   = 1'b1;
                    next_state = IDLE;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State, latched op and a saturating wait timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_q  <= '0;
            timer <= '0;
        end else begin
            state <= next_state;
            if (start_wait) begin
                op_q  <= req_op;
                timer <= '0;
            end else if (timer_inc && (timer != '1)) begin
                timer <= timer + 1'b1;
            end
        end
    end

    assign push_dat  = push_err ? '0 : sel_data;
    assign push_word = {push_dat, sel, push_err};
    assign pop       = out_valid & out_ready;
    assign out_valid = (count != 2'd0);

    result_fifo2 #(
        .DW (DW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

    assign {out_data, out_op, out_err} = head;

endmodule

// File: tb/tb_alu_result_select.sv
// Directed bench for alu_result_select: a default instance (8 units, long timeout)
// and a narrow instance (6 units, TIMEOUT=4) for illegal-op and timeout cases.
module tb_alu_result_select;
    import alu_sel_pkg::*;

    logic clk;
    logic rst_n;

    logic [255:0] in_data_a;
    logic [7:0]   in_valid_a;
    logic [2:0]   req_op_a;
    logic         req_valid_a, req_ready_a;
    logic [31:0]  out_data_a;
    logic [2:0]   out_op_a;
    logic         out_err_a, out_valid_a, out_ready_a, busy_a;

    logic [191:0] in_data_b;
    logic [5:0]   in_valid_b;
    logic [2:0]   req_op_b;
    logic         req_valid_b, req_ready_b;
    logic [31:0]  out_data_b;
    logic [2:0]   out_op_b;
    logic         out_err_b, out_valid_b, out_ready_b, busy_b;

    int checks = 0;
    int passed = 0;

    typedef struct {
        bit          dsel;
        logic [2:0]  op;
        logic        v;
        logic [31:0] d;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  op;
        logic        e;
    } res_t;

    vec_t vecs [8];
    res_t held_a;
    res_t held_b;

    alu_result_select #(.WIDTH(32), .NUM_IN(8), .TIMEOUT(64)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_a), .in_valid(in_valid_a),
        .req_op(req_op_a), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .out_data(out_data_a), .out_op(out_op_a), .out_err(out_err_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .busy(busy_a)
    );

    alu_result_select #(.WIDTH(32), .NUM_IN(6), .TIMEOUT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_b), .in_valid(in_valid_b),
        .req_op(req_op_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .out_data(out_data_b), .out_op(out_op_b), .out_err(out_err_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit dsel, input logic [2:0] op, input logic v,
                                 input logic [31:0] d);
        int idx;
        idx = int'(op);
        if (!dsel) begin
            in_valid_a  = '0;
            req_op_a    = op;
            req_valid_a = 1'b1;
            if (v) begin
                in_valid_a[idx]          = 1'b1;
                in_data_a[idx*32 +: 32]  = d;
            end
        end else begin
            in_valid_b  = '0;
            req_op_b    = op;
            req_valid_b = 1'b1;
            if (v && idx < 6) begin
                in_valid_b[idx]          = 1'b1;
                in_data_b[idx*32 +: 32]  = d;
            end
        end
    endtask

    task automatic clearReq(input bit dsel);
        if (!dsel) begin
            req_valid_a = 1'b0;
            in_valid_a  = '0;
        end else begin
            req_valid_b = 1'b0;
            in_valid_b  = '0;
        end
    endtask

    task automatic checkOutput(input string name, input bit dsel, input logic ev,
                               input logic [31:0] ed, input logic [2:0] eo, input logic ee,
                               input logic eb, input logic er);
        logic [38:0] act;
        logic [38:0] exp;
        if (!dsel) act = {out_valid_a, out_data_a, out_op_a, out_err_a, busy_a, req_ready_a};
        else       act = {out_valid_b, out_data_b, out_op_b, out_err_b, busy_b, req_ready_b};
        exp = {ev, ed, eo, ee, eb, er};
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got valid=%b data=%h op=%0d err=%b busy=%b ready=%b, want valid=%b data=%h op=%0d err=%b busy=%b ready=%b",
                     name, act[38], act[37:6], act[5:3], act[2], act[1], act[0],
                     ev, ed, eo, ee, eb, er);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        in_data_a   = '0; in_valid_a = '0; req_op_a = '0; req_valid_a = 1'b0; out_ready_a = 1'b1;
        in_data_b   = '0; in_valid_b = '0; req_op_b = '0; req_valid_b = 1'b0; out_ready_b = 1'b1;
        held_a      = '{32'h0, 3'd0, 1'b0};
        held_b      = '{32'h0, 3'd0, 1'b0};

        vecs[0] = '{1'b0, OP_ADD, 1'b1, 32'h0000_0007, 32'h0000_0007, 1'b0};
        vecs[1] = '{1'b0, OP_AND, 1'b1, 32'hA5A5_0001, 32'hA5A5_0001, 1'b0};
        vecs[2] = '{1'b0, OP_SLT, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        vecs[3] = '{1'b0, OP_MOD, 1'b1, 32'h1234_5678, 32'h1234_5678, 1'b0};
        vecs[4] = '{1'b1, OP_SLT, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vecs[5] = '{1'b1, OP_NOR, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[6] = '{1'b1, OP_MOD, 1'b1, 32'h5555_5555, 32'h0000_0000, 1'b1};
        vecs[7] = '{1'b1, OP_AND, 1'b1, 32'h0000_0042, 32'h0000_0042, 1'b0};

        #12;
        checkOutput("reset_a", 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("reset_b", 1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1);
        #10 rst_n = 1'b1;
        tick();
        checkOutput("post_reset_a", 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1);

        // single-cycle requests: accept, result next cycle, then popped and held
        for (int i = 0; i < 8; i++) begin
            res_t h;
            h = vecs[i].dsel ? held_b : held_a;
            applyStimulus(vecs[i].dsel, vecs[i].op, vecs[i].v, vecs[i].d);
            checkOutput($sformatf("vec%0d_pre", i), vecs[i].dsel, 1'b0, h.d, h.op, h.e, 1'b0, 1'b1);
            tick();
            clearReq(vecs[i].dsel);
            checkOutput($sformatf("vec%0d_out", i), vecs[i].dsel, 1'b1, vecs[i].exp_d, vecs[i].op,
                        vecs[i].exp_e, 1'b0, 1'b1);
            tick();
            checkOutput($sformatf("vec%0d_held", i), vecs[i].dsel, 1'b0, vecs[i].exp_d, vecs[i].op,
                        vecs[i].exp_e, 1'b0, 1'b1);
            h = '{vecs[i].exp_d, vecs[i].op, vecs[i].exp_e};
            if (vecs[i].dsel) held_b = h;
            else              held_a = h;
        end

        // multi-cycle MOD: busy for five cycles, then the late result
        applyStimulus(1'b0, OP_MOD, 1'b0, 32'h0);
        tick();
        clearReq(1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("wait_busy%0d", i), 1'b0, 1'b0, held_a.d, held_a.op, held_a.e,
                        1'b1, 1'b0);
            if (i < 4) tick();
        end
        in_valid_a[7]        = 1'b1;
        in_data_a[224 +: 32] = 32'h0000_0003;
        tick();
        in_valid_a = '0;
        checkOutput("wait_result", 1'b0, 1'b1, 32'h3, OP_MOD, 1'b0, 1'b0, 1'b1);
        tick();
        held_a = '{32'h3, OP_MOD, 1'b0};

        // timeout on the narrow instance: four WAIT cycles then an error result
        applyStimulus(1'b1, OP_SLT, 1'b0, 32'h0);
        tick();
        clearReq(1'b1);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("to_busy%0d", i), 1'b1, 1'b0, held_b.d, held_b.op, held_b.e,
                        1'b1, 1'b0);
            tick();
        end
        checkOutput("timeout_err", 1'b1, 1'b1, 32'h0, OP_SLT, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("timeout_idle", 1'b1, 1'b0, 32'h0, OP_SLT, 1'b1, 1'b0, 1'b1);

        // result arriving in the final timeout cycle wins over the error
        applyStimulus(1'b1, OP_XOR, 1'b0, 32'h0);
        tick();
        clearReq(1'b1);
        tick();
        tick();
        tick();
        checkOutput("race_busy", 1'b1, 1'b0, 32'h0, OP_SLT, 1'b1, 1'b1, 1'b0);
        in_valid_b[4]        = 1'b1;
        in_data_b[128 +: 32] = 32'h0000_0077;
        tick();
        in_valid_b = '0;
        checkOutput("race_data_wins", 1'b1, 1'b1, 32'h77, OP_XOR, 1'b0, 1'b0, 1'b1);
        tick();

        // backpressure: buffer fills, drains in order, then reset mid-WAIT
        out_ready_a = 1'b0;
        applyStimulus(1'b0, OP_AND, 1'b1, 32'h10);
        tick();
        applyStimulus(1'b0, OP_OR, 1'b1, 32'h11);
        checkOutput("bp_one", 1'b0, 1'b1, 32'h10, OP_AND, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, OP_ADD, 1'b1, 32'h12);
        checkOutput("bp_full", 1'b0, 1'b1, 32'h10, OP_AND, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("bp_stable", 1'b0, 1'b1, 32'h10, OP_AND, 1'b0, 1'b0, 1'b0);
        out_ready_a = 1'b1;
        tick();
        checkOutput("bp_pop0", 1'b0, 1'b1, 32'h11, OP_OR, 1'b0, 1'b0, 1'b1);
        tick();
        clearReq(1'b0);
        checkOutput("bp_pushpop", 1'b0, 1'b1, 32'h12, OP_ADD, 1'b0, 1'b0, 1'b1);
        out_ready_a = 1'b0;
        applyStimulus(1'b0, OP_SUB, 1'b0, 32'h0);
        tick();
        clearReq(1'b0);
        checkOutput("bp_wait", 1'b0, 1'b1, 32'h12, OP_ADD, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reset", 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1);
        #2 rst_n = 1'b1;
        out_ready_a = 1'b1;
        tick();
        checkOutput("after_reset", 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
